// File: rtl/mod256_pkg.sv
// Shared width, terminal value and FSM state type for the mod-256 index sequencers.
package mod256_pkg;
    localparam int COUNT_W = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;
endpackage

// File: rtl/mod256_up_core.sv
// 8-bit index register: synchronous clear, increment enable, terminal-count decode.
module mod256_up_core
    import mod256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [COUNT_W-1:0] count,
    output logic               at_max
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == COUNT_MAX);
endmodule

// File: rtl/mod256_up_sequencer.sv
// Ascending 0..255 index sequencer with step handshake, last flag and done pulse.
// MOD256_UP_SEQ_WRAP_EN: free-running wrap at 8'hFF instead of one-shot completion.
module mod256_up_sequencer
    import mod256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic               abort,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               last,
    output logic               done
);
    seq_state_t state, state_nxt;
    logic       busy_nxt, done_nxt;
    logic       clr, inc, at_max;

    mod256_up_core u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .inc    (inc),
        .count  (count),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        clr       = 1'b0;
        inc       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    clr       = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (start) begin
                    clr = 1'b1;
                end else if (step) begin
                    if (at_max) begin
`ifdef MOD256_UP_SEQ_WRAP_EN
                        inc      = 1'b1;
                        done_nxt = 1'b1;
`else
                        // count holds at the terminal value through DONE and IDLE
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
`endif
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    clr       = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign last = (state == RUN) && at_max;
endmodule

// File: tb/tb_mod256_up_sequencer.sv
// Randomized and directed checks of mod256_up_sequencer against an integer reference model.
module tb_mod256_up_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, step, abort;
    logic [7:0] count;
    logic       busy, last, done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: running flag, integer index, pending done pulse
    bit m_run;
    int m_cnt;
    bit m_done;

    mod256_up_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .step  (step),
        .abort (abort),
        .count (count),
        .busy  (busy),
        .last  (last),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit st, input bit a);
        rst = r; start = s; step = st; abort = a;
    endtask

    function automatic void model_update();
        if (rst) begin
            m_run = 0; m_cnt = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_cnt = 0;
            end
        end else if (abort) begin
            m_run = 0; m_cnt = 0;
        end else if (start) begin
            m_cnt = 0;
        end else if (step) begin
            if (m_cnt == 255) begin
                m_done = 1;
`ifdef MOD256_UP_SEQ_WRAP_EN
                m_cnt = 0;
`else
                m_run = 0;
`endif
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        chk("count", int'(count), m_cnt);
        chk("busy", int'(busy), int'(m_run));
        chk("last", int'(last), int'(m_run && m_cnt == 255));
        chk("done", int'(done), int'(m_done));
    endtask

    initial begin
        int n, acc, pulses;
        bit seen;

        drive(1, 0, 0, 0);
        m_run = 0; m_cnt = 0; m_done = 0;
        tick();
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);

        // full sequence with step held high
        drive(0, 1, 0, 0); tick();
        n = 1; seen = 0;
        drive(0, 0, 1, 0);
        while (!seen && n < 400) begin
            tick(); n++;
            if (done) seen = 1;
        end
        chk("full_done_seen", int'(seen), 1);
        chk("full_start_to_done", n, 257);
        drive(0, 0, 0, 0); tick();
`ifdef MOD256_UP_SEQ_WRAP_EN
        chk("wrap_post_busy", int'(busy), 1);
        chk("wrap_post_count", int'(count), 0);
        drive(0, 0, 0, 1); tick();
`else
        chk("post_busy", int'(busy), 0);
        chk("post_count", int'(count), 255);
`endif

        // gapped steps, one in three cycles
        drive(0, 1, 0, 0); tick();
        acc = 0; seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            drive(0, 0, (i % 3) == 2, 0);
            if (step && m_run) acc++;
            tick();
            if (done) seen = 1;
        end
        chk("gap_done_seen", int'(seen), 1);
        chk("gap_accepted", acc, 256);
        drive(0, 0, 0, 1); tick();

        // abort at 0x40
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 64; i++) tick();
        chk("pre_abort_count", int'(count), 'h40);
        drive(0, 0, 0, 1); tick();
        chk("abort_count", int'(count), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);

        // restart at 0x80, then abort+start together
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 128; i++) tick();
        drive(0, 1, 1, 0); tick();
        chk("restart_count", int'(count), 0);
        chk("restart_busy", int'(busy), 1);
        drive(0, 1, 1, 1); tick();
        chk("abort_start_busy", int'(busy), 0);

        // reset at 0xFE with step high
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 1, 0);
        for (int i = 0; i < 254; i++) tick();
        chk("pre_rst_count", int'(count), 'hFE);
        drive(1, 0, 1, 0); tick();
        chk("rst_fe_count", int'(count), 0);
        chk("rst_fe_busy", int'(busy), 0);
        chk("rst_fe_last", int'(last), 0);
        chk("rst_fe_done", int'(done), 0);

`ifdef MOD256_UP_SEQ_WRAP_EN
        drive(0, 1, 0, 0); tick();
        pulses = 0;
        drive(0, 0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("wrap_pulses", pulses, 1);
        chk("wrap_busy", int'(busy), 1);
        chk("wrap_count", int'(count), 300 - 256);
        drive(0, 0, 0, 1); tick();
`endif

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            drive($urandom_range(0, 499) == 0,
                  $urandom_range(0, 299) == 0,
                  $urandom_range(0, 9) < 8,
                  $urandom_range(0, 399) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
